hilo_mdu: RTL and testbench

- Parametrised multiply/divide unit with its own HI/LO registers, sitting in the EXE stage beside the ALU.
- Accepts one HI/LO-class operation at a time: MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MTHI, MTLO.
- Uses a pipelined multiplier and an iterative radix-2 divider.
- Raises a stall to freeze the pipeline while an operation is in flight; can be cancelled by an exception flush.

---
 rtl/hilo_mdu_if.sv | 26 ++
 rtl/hilo_mdu.sv | 188 ++++++++++++++++++
 tb/tb_hilo_mdu.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_mdu_if.sv
// Operation/result bundle between the EXE stage and the HI/LO multiply-divide unit.
// The master presents operations; the slave owns HI/LO and reports stall/busy/done.
interface hilo_mdu_if #(
  parameter int WIDTH = 32
);
  logic             op_valid;
  logic [3:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output op_valid, op, src_a, src_b, flush,
    input  stall, busy, done, hi, lo
  );

  modport slave (
    input  op_valid, op, src_a, src_b, flush,
    output stall, busy, done, hi, lo
  );
endinterface

// File: rtl/hilo_mdu.sv
// HI/LO multiply/divide unit: pipelined multiplier with optional accumulate,
// restoring radix-2 divider with a sign-fixup cycle, flushable while busy.
module hilo_mdu #(
  parameter int               WIDTH      = 32,
  parameter int               MUL_STAGES = 2,
  parameter logic [WIDTH-1:0] DIV_ZERO_Q = {WIDTH{1'b1}}
) (
  input logic       clk,
  input logic       resetn,
  hilo_mdu_if.slave mdu
);
  localparam int DW      = 2 * WIDTH;
  localparam int CNT_MAX = (WIDTH > MUL_STAGES) ? WIDTH : MUL_STAGES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_DIV = 2'd2, ST_DFIX = 2'd3} state_t;
  typedef enum logic [1:0] {ACC_SET = 2'd0, ACC_ADD = 2'd1, ACC_SUB = 2'd2} acc_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  acc_t             acc_r;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic             done_r;
  logic [DW-1:0]    prod_pipe_r [MUL_STAGES];
  logic [WIDTH-1:0] rem_r, quo_r, dvs_r, dvd_r;
  logic             q_neg_r, r_neg_r, dvz_r;

  logic             is_mul_s, is_div_s, sgn_s, accept_s, busy_s;
  acc_t             acc_s;
  logic [DW-1:0]    ext_a_s, ext_b_s, product_s, mul_res_s;
  logic             a_neg_s, b_neg_s;
  logic [WIDTH-1:0] a_mag_s, b_mag_s, quo_fix_s, rem_fix_s;
  logic [WIDTH:0]   shift_s, trial_s;

  // Decode the presented operation into class, signedness and accumulate mode.
  always_comb begin
    is_mul_s = 1'b0;
    is_div_s = 1'b0;
    sgn_s    = 1'b0;
    acc_s    = ACC_SET;
    case (mdu.op)
      4'd0:    begin is_mul_s = 1'b1; sgn_s = 1'b1; end
      4'd1:    begin is_mul_s = 1'b1; end
      4'd2:    begin is_div_s = 1'b1; sgn_s = 1'b1; end
      4'd3:    begin is_div_s = 1'b1; end
      4'd4:    begin is_mul_s = 1'b1; sgn_s = 1'b1; acc_s = ACC_ADD; end
      4'd5:    begin is_mul_s = 1'b1; acc_s = ACC_ADD; end
      4'd6:    begin is_mul_s = 1'b1; sgn_s = 1'b1; acc_s = ACC_SUB; end
      4'd7:    begin is_mul_s = 1'b1; acc_s = ACC_SUB; end
      default: begin is_mul_s = 1'b0; end
    endcase
  end

  assign accept_s = (state_r == ST_IDLE) & mdu.op_valid & ~mdu.flush;
  assign busy_s   = (state_r != ST_IDLE);

  // A 2W-bit product of extended operands is the exact result mod 2^(2W) for both signednesses.
  assign ext_a_s   = sgn_s ? {{WIDTH{mdu.src_a[WIDTH-1]}}, mdu.src_a} : {{WIDTH{1'b0}}, mdu.src_a};
  assign ext_b_s   = sgn_s ? {{WIDTH{mdu.src_b[WIDTH-1]}}, mdu.src_b} : {{WIDTH{1'b0}}, mdu.src_b};
  assign product_s = ext_a_s * ext_b_s;

  assign a_neg_s = sgn_s & mdu.src_a[WIDTH-1];
  assign b_neg_s = sgn_s & mdu.src_b[WIDTH-1];
  assign a_mag_s = a_neg_s ? ({WIDTH{1'b0}} - mdu.src_a) : mdu.src_a;
  assign b_mag_s = b_neg_s ? ({WIDTH{1'b0}} - mdu.src_b) : mdu.src_b;

  // One restoring step: a borrow out of the trial subtraction means keep the shifted remainder.
  assign shift_s = {rem_r, quo_r[WIDTH-1]};
  assign trial_s = shift_s - {1'b0, dvs_r};

  // Final multiply write value, optionally accumulated onto the current HI/LO.
  always_comb begin
    mul_res_s = prod_pipe_r[MUL_STAGES-1];
    case (acc_r)
      ACC_ADD: mul_res_s = {hi_r, lo_r} + prod_pipe_r[MUL_STAGES-1];
      ACC_SUB: mul_res_s = {hi_r, lo_r} - prod_pipe_r[MUL_STAGES-1];
      default: mul_res_s = prod_pipe_r[MUL_STAGES-1];
    endcase
  end

  // Sign fix-up of the unsigned divider result, with divide-by-zero override.
  always_comb begin
    if (dvz_r) begin
      quo_fix_s = DIV_ZERO_Q;
      rem_fix_s = dvd_r;
    end else begin
      quo_fix_s = q_neg_r ? ({WIDTH{1'b0}} - quo_r) : quo_r;
      rem_fix_s = r_neg_r ? ({WIDTH{1'b0}} - rem_r) : rem_r;
    end
  end

  // Multiplier pipeline: first stage multiplies the live operands, later stages delay.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < MUL_STAGES; i++) prod_pipe_r[i] <= {DW{1'b0}};
    end else begin
      prod_pipe_r[0] <= product_s;
      for (int i = 1; i < MUL_STAGES; i++) prod_pipe_r[i] <= prod_pipe_r[i-1];
    end
  end

  // Control FSM, divider datapath and the HI/LO architectural registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      acc_r   <= ACC_SET;
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
      done_r  <= 1'b0;
      rem_r   <= {WIDTH{1'b0}};
      quo_r   <= {WIDTH{1'b0}};
      dvs_r   <= {WIDTH{1'b0}};
      dvd_r   <= {WIDTH{1'b0}};
      q_neg_r <= 1'b0;
      r_neg_r <= 1'b0;
      dvz_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            if (is_mul_s) begin
              state_r <= ST_MUL;
              cnt_r   <= CNT_W'(MUL_STAGES - 1);
              acc_r   <= acc_s;
            end else if (is_div_s) begin
              state_r <= ST_DIV;
              cnt_r   <= CNT_W'(WIDTH - 1);
              rem_r   <= {WIDTH{1'b0}};
              quo_r   <= a_mag_s;
              dvs_r   <= b_mag_s;
              dvd_r   <= mdu.src_a;
              q_neg_r <= a_neg_s ^ b_neg_s;
              r_neg_r <= a_neg_s;
              dvz_r   <= (mdu.src_b == {WIDTH{1'b0}});
            end else if (mdu.op == 4'd8) begin
              hi_r <= mdu.src_a;
            end else if (mdu.op == 4'd9) begin
              lo_r <= mdu.src_a;
            end
          end
        end
        ST_MUL: begin
          if (mdu.flush) begin
            state_r <= ST_IDLE;
          end else if (cnt_r == {CNT_W{1'b0}}) begin
            {hi_r, lo_r} <= mul_res_s;
            done_r       <= 1'b1;
            state_r      <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        ST_DIV: begin
          if (mdu.flush) begin
            state_r <= ST_IDLE;
          end else begin
            if (trial_s[WIDTH]) begin
              rem_r <= shift_s[WIDTH-1:0];
              quo_r <= {quo_r[WIDTH-2:0], 1'b0};
            end else begin
              rem_r <= trial_s[WIDTH-1:0];
              quo_r <= {quo_r[WIDTH-2:0], 1'b1};
            end
            if (cnt_r == {CNT_W{1'b0}}) state_r <= ST_DFIX;
            else                        cnt_r   <= cnt_r - CNT_W'(1);
          end
        end
        ST_DFIX: begin
          if (!mdu.flush) begin
            lo_r   <= quo_fix_s;
            hi_r   <= rem_fix_s;
            done_r <= 1'b1;
          end
          state_r <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign mdu.stall = busy_s | (mdu.op_valid & (is_mul_s | is_div_s) & ~mdu.flush);
  assign mdu.busy  = busy_s;
  assign mdu.done  = done_r;
  assign mdu.hi    = hi_r;
  assign mdu.lo    = lo_r;
endmodule

// File: tb/tb_hilo_mdu.sv
// Directed testbench for hilo_mdu: expected HI/LO results are queued when an
// operation is issued and compared when the unit signals done.
module tb_hilo_mdu;
  localparam logic [3:0] OP_MULT = 4'd0, OP_MULTU = 4'd1, OP_DIV = 4'd2, OP_DIVU = 4'd3;
  localparam logic [3:0] OP_MADDU = 4'd5, OP_MSUB = 4'd6, OP_MTHI = 4'd8, OP_MTLO = 4'd9;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 33;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [63:0] sb_q[$];
  logic [63:0] m_hl = 64'd0;
  logic [63:0] saved;

  hilo_mdu_if #(.WIDTH(32)) bus ();

  hilo_mdu #(.WIDTH(32), .MUL_STAGES(2), .DIV_ZERO_Q(32'hFFFF_FFFF)) dut (
    .clk    (clk),
    .resetn (resetn),
    .mdu    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] hl);
    longint ps;
    logic [63:0] pu;
    int ia, ib, q, r;
    ps = longint'($signed(a)) * longint'($signed(b));
    pu = {32'd0, a} * {32'd0, b};
    ia = a;
    ib = b;
    case (op)
      4'd0: return ps;
      4'd1: return pu;
      4'd4: return hl + ps;
      4'd5: return hl + pu;
      4'd6: return hl - ps;
      4'd7: return hl - pu;
      4'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = ia / ib;
        r = ia % ib;
        return {32'(r), 32'(q)};
      end
      4'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return hl;
    endcase
  endfunction

  // Present one op for exactly one accepting edge; returns #1 after that edge.
  task automatic present(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op = op;
    bus.src_a = a;
    bus.src_b = b;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int n = 0;
    logic [63:0] e;
    while (bus.done !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(exp_lat));
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s: observed=no queued result expected=queued result", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, " hilo"}, {bus.hi, bus.lo}, e);
    end
    @(posedge clk);
    #1;
    chk({tag, " done pulse"}, 64'(bus.done), 64'd0);
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [63:0] exp, input int lat);
    sb_q.push_back(exp);
    m_hl = exp;
    present(op, a, b);
    wait_done(tag, lat);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int dsum;
    bus.op_valid = 1'b0;
    bus.op = 4'd0;
    bus.src_a = 32'd0;
    bus.src_b = 32'd0;
    bus.flush = 1'b0;
    #1;
    chk("reset hilo", {bus.hi, bus.lo}, 64'd0);
    chk("reset busy/done", {62'd0, bus.busy, bus.done}, 64'd0);
    #20;
    @(negedge clk);
    resetn = 1'b1;

    present(OP_MTHI, 32'h1111_1111, 32'd0);
    chk("mthi", {bus.hi, bus.lo}, {32'h1111_1111, 32'd0});
    present(OP_MTLO, 32'h2222_2222, 32'd0);
    chk("mtlo", {bus.hi, bus.lo}, {32'h1111_1111, 32'h2222_2222});
    chk("mt no busy/done", {62'd0, bus.busy, bus.done}, 64'd0);
    present(4'hC, 32'hDEAD_BEEF, 32'h1);
    @(posedge clk);
    #1;
    chk("undef op", {bus.hi, bus.lo, 31'd0, bus.busy}, {32'h1111_1111, 32'h2222_2222, 32'd0});

    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op = OP_MULT;
    #1;
    chk("stall comb", 64'(bus.stall), 64'd1);
    bus.flush = 1'b1;
    #1;
    chk("stall flush", 64'(bus.stall), 64'd0);
    bus.op_valid = 1'b0;
    bus.flush = 1'b0;

    run("mult", OP_MULT, 32'hFFFF_FFFE, 32'h3, {32'hFFFF_FFFF, 32'hFFFF_FFFA}, MUL_LAT);
    run("multu", OP_MULTU, 32'hFFFF_FFFE, 32'h3, {32'h0000_0002, 32'hFFFF_FFFA}, MUL_LAT);
    run("maddu", OP_MADDU, 32'h1, 32'h6, {32'h0000_0003, 32'h0000_0000}, MUL_LAT);
    run("div", OP_DIV, 32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, DIV_LAT);
    run("divu", OP_DIVU, 32'h7, 32'h2, {32'h1, 32'h3}, DIV_LAT);
    run("divu zero", OP_DIVU, 32'h1234_5678, 32'h0, {32'h1234_5678, 32'hFFFF_FFFF}, DIV_LAT);
    run("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, DIV_LAT);
    run("msub", OP_MSUB, 32'h5, 32'h3, {32'h0, 32'h7FFF_FFF1}, MUL_LAT);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 2 || i == 3) rb = rb >> $urandom_range(28, 4);
      run($sformatf("rand op%0d", i), 4'(i), ra, rb, model(4'(i), ra, rb, m_hl),
          (i == 2 || i == 3) ? DIV_LAT : MUL_LAT);
    end

    saved = {bus.hi, bus.lo};
    present(OP_MULT, 32'h7, 32'h9);
    @(posedge clk);
    #1;
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("mul flush final", {bus.hi, bus.lo}, saved);
    chk("mul flush busy/done", {62'd0, bus.busy, bus.done}, 64'd0);

    present(OP_DIV, 32'h0000_0064, 32'h7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("div flush busy", 64'(bus.busy), 64'd0);
    dsum = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) dsum++;
    end
    chk("div flush no done", 64'(dsum), 64'd0);
    chk("div flush hilo", {bus.hi, bus.lo}, saved);

    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op = OP_MTHI;
    bus.src_a = 32'hA5A5_A5A5;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    bus.flush = 1'b0;
    chk("mthi flushed", {bus.hi, bus.lo}, saved);

    sb_q.push_back({32'h1, 32'h3});
    present(OP_DIVU, 32'h7, 32'h2);
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op = OP_MTLO;
    bus.src_a = 32'h1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("mtlo busy stall%0d", k), {31'd0, bus.stall, bus.lo}, {31'd0, 1'b1, saved[31:0]});
    end
    bus.op_valid = 1'b0;
    wait_done("divu w/ mtlo", DIV_LAT - 3);

    present(OP_DIV, 32'hFFFF_FF00, 32'h3);
    repeat (5) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk("async rst hilo", {bus.hi, bus.lo}, 64'd0);
    chk("async rst busy/done", {62'd0, bus.busy, bus.done}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post rst idle", {bus.hi, bus.lo, 31'd0, bus.busy}, {64'd0, 32'd0});
    chk("scoreboard drained", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
